// File: rtl/pcap_tb_pkg.sv
// Shared types and helpers for the pcap stream arbiter: FSM state encoding,
// round-robin pick function and index-width derivation.
package pcap_tb_pkg;

  localparam int MAX_SRC   = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req searching upward from ptr, wrapping at num.
  // With no request set the pointer is returned unchanged.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          num
  );
    logic                 found;
    logic [MAX_IDX_W-1:0] pick;
    int unsigned          k;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      k = 32'(ptr) + i;
      if (k >= num) k = k - num;
      if (!found && (i < num) && req[k[MAX_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = k[MAX_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pcap_stream_arbiter_skid.sv
// Two-entry full-throughput AXIS skid buffer with a registered output stage.
// Upstream ready depends only on local state, so it breaks the ready path.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;

  assign in_ready  = !skid_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees this cycle: drain the skid entry first, else pass through.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid && in_ready) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the two data entries are reset as well, because m_tdata/m_tkeep/m_tlast must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/pcap_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXIS pcap replay streams into one
// stream; a packet owns the output from its first beat until its tlast.
module pcap_stream_arbiter
  import pcap_tb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 512,
  parameter  int MAX_BEATS  = 64,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = idx_width(NUM_SRC)
) (
  input  logic                          clk_out,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]            s_tlast,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic [15:0]                   pkt_count,
  output logic                          err_overlong
);

  localparam int               PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int               BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              err_q, err_d;

  logic [NUM_SRC-1:0]    req;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic [PAYLOAD_W-1:0]  skid_out_data;

  assign req = s_tvalid & src_en;

  always_comb begin
    sel_data  = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_keep  = s_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    sel_last  = s_tlast[grant_q];
    sel_valid = s_tvalid[grant_q];
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    s_tready      = '0;
    skid_in_valid = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = IDX_W'(rr_pick(MAX_SRC'(req), MAX_IDX_W'(rr_ptr_q), NUM_SRC));
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        s_tready[grant_q] = skid_in_ready;
        skid_in_valid     = sel_valid;
        if (sel_valid && skid_in_ready) begin
          // Counter saturates at MAX_BEATS: reaching it means this beat is number MAX_BEATS+1 or later.
          if (beat_cnt_q < BEAT_MAX) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (!sel_last && (beat_cnt_q == BEAT_MAX)) err_d = 1'b1;
          if (sel_last) begin
            rr_ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
            beat_cnt_d = '0;
            state_d    = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (m_tvalid && m_tready && m_tlast) pkt_count_d = pkt_count_q + 16'd1;
  end

  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  axis_skid_buf #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (clk_out),
    .rst_n    (reset_n),
    .in_data  ({sel_data, sel_keep, sel_last}),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .out_data (skid_out_data),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

  assign {m_tdata, m_tkeep, m_tlast} = skid_out_data;
  assign grant_idx    = grant_q;
  assign busy         = (state_q == ARB_LOCK);
  assign pkt_count    = pkt_count_q;
  assign err_overlong = err_q;

endmodule

// File: tb/tb_pcap_stream_arbiter.sv
// Self-checking bench for pcap_stream_arbiter: queue-driven sources, a packet-level
// round-robin reference model and a scoreboard on the merged output.
module tb_pcap_stream_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int MB = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk_out;
  logic             reset_n;
  logic [NS-1:0]    src_en;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [15:0]      pkt_count;
  logic             err_overlong;

  pcap_stream_arbiter #(
    .NUM_SRC   (NS),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk_out     (clk_out),
    .reset_n     (reset_n),
    .src_en      (src_en),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .err_overlong(err_overlong)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    exp_grants[$];
  int    grant_log[$];
  bit    mid_pkt[NS];
  int    beat_no[NS];
  int    cyc = 0;
  int    last_tlast_cyc = -1;
  int    inflight = 0;
  int    pkt_model = 0;
  int    mptr = 0;
  int    seq = 0;
  int    pat_cnt = 0;
  int    ready_mode = 0;
  bit    err_model = 0;
  bit    prev_stall = 0;
  bit    acc_prev_valid = 0;
  bit    lat_en = 0;
  bit    bubble_exact = 0;
  bit    gap_en = 0;
  beat_t prev_beat;
  beat_t acc_prev_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int k, input int nbeats, input bit rnd_keep);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {8'(k), 8'(seq), 16'(i + 1)};
      b.keep = rnd_keep ? 4'($urandom) : 4'hF;
      b.last = (i == nbeats - 1);
      src_q[k].push_back(b);
    end
    seq++;
  endtask

  // Reference: whole packets granted in rotation among enabled sources with pending packets.
  task automatic schedule(input logic [NS-1:0] en);
    beat_t cp[NS][$];
    beat_t b;
    int    found;
    int    k;
    for (int s = 0; s < NS; s++) cp[s] = src_q[s];
    exp_grants.delete();
    grant_log.delete();
    forever begin
      found = -1;
      for (int i = 0; i < NS; i++) begin
        k = (mptr + i) % NS;
        if (found < 0 && en[k] && cp[k].size() > 0) found = k;
      end
      if (found < 0) break;
      exp_grants.push_back(found);
      do begin
        b = cp[found].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      mptr = (found + 1) % NS;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < NS; k++) begin
      if (src_q[k].size() > 0) begin
        b = src_q[k][0];
        s_tdata[k*DW +: DW] = b.data;
        s_tkeep[k*KW +: KW] = b.keep;
        s_tlast[k]          = b.last;
        s_tvalid[k]         = !mid_pkt[k] || !gap_en || ($urandom_range(3) != 0);
      end else begin
        s_tdata[k*DW +: DW] = '0;
        s_tkeep[k*KW +: KW] = '0;
        s_tlast[k]          = 1'b0;
        s_tvalid[k]         = 1'b0;
      end
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(3) != 0);
      default: m_tready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
    endcase
    pat_cnt++;
  endtask

  // One clock: sample at negedge, account for the handshakes of the coming edge, drive after it.
  task automatic tick();
    beat_t cur;
    beat_t b;
    @(negedge clk_out);
    cur = {m_tdata, m_tkeep, m_tlast};
    check("s_tready_onehot0", 64'($onehot0(s_tready)), 64'(1));
    check("pkt_count", 64'(pkt_count), 64'(pkt_model & 16'hFFFF));
    check("err_overlong", 64'(err_overlong), 64'(err_model));
    if (prev_stall) begin
      check("stall_valid", 64'(m_tvalid), 64'(1));
      check("stall_payload", 64'(cur), 64'(prev_beat));
    end
    if (lat_en && acc_prev_valid) begin
      check("latency_valid", 64'(m_tvalid), 64'(1));
      check("latency_payload", 64'(cur), 64'(acc_prev_beat));
    end
    if (m_tvalid && m_tready) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("out_beat", 64'(cur), 64'(b));
      end
      if (m_tlast) pkt_model++;
      inflight--;
    end
    acc_prev_valid = 0;
    for (int k = 0; k < NS; k++) begin
      if (s_tvalid[k] && s_tready[k]) begin
        b = src_q[k].pop_front();
        check("grant_idx", 64'(grant_idx), 64'(k));
        check("busy", 64'(busy), 64'(1));
        if (!mid_pkt[k]) begin
          if (last_tlast_cyc >= 0) begin
            check("bubble_min", 64'((cyc - last_tlast_cyc) >= 2), 64'(1));
            if (bubble_exact) check("bubble_exact", 64'(cyc - last_tlast_cyc), 64'(2));
          end
          grant_log.push_back(k);
          beat_no[k] = 0;
        end
        beat_no[k]++;
        if (beat_no[k] > MB && !b.last) err_model = 1;
        mid_pkt[k] = !b.last;
        if (b.last) last_tlast_cyc = cyc;
        inflight++;
        acc_prev_valid = 1;
        acc_prev_beat  = b;
      end
    end
    check("inflight_max2", 64'(inflight <= 2), 64'(1));
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = cur;
    @(posedge clk_out);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    tick();
    check({tag, "_grant_count"}, 64'(grant_log.size()), 64'(exp_grants.size()));
    for (int i = 0; i < grant_log.size() && i < exp_grants.size(); i++)
      check({tag, "_grant_order"}, 64'(grant_log[i]), 64'(exp_grants[i]));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_grant_idx", 64'(grant_idx), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_err_overlong", 64'(err_overlong), 64'(0));
    for (int k = 0; k < NS; k++) begin
      src_q[k].delete();
      mid_pkt[k] = 0;
      beat_no[k] = 0;
    end
    exp_q.delete();
    exp_grants.delete();
    grant_log.delete();
    inflight       = 0;
    pkt_model      = 0;
    err_model      = 0;
    mptr           = 0;
    last_tlast_cyc = -1;
    prev_stall     = 0;
    acc_prev_valid = 0;
    drive();
    repeat (2) @(posedge clk_out);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b1;
    src_en  = '1;
    drive();
    #2;
    apply_reset();

    // 1) single 3-beat packet from source 0, downstream always ready
    lat_en = 1;
    add_pkt(0, 3, 0);
    schedule(4'b1111);
    drive();
    run_until_drained("t1", 50);
    check("t1_pkt_count", 64'(pkt_count), 64'(1));
    check("t1_grant_idx", 64'(grant_idx), 64'(0));

    // 2) all sources hold 1-beat packets: rotation 0,1,2,3,0 with one bubble each
    apply_reset();
    bubble_exact = 1;
    for (int k = 0; k < NS; k++) add_pkt(k, 1, 0);
    add_pkt(0, 1, 0);
    schedule(4'b1111);
    drive();
    run_until_drained("t2", 60);
    check("t2_grants", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < grant_log.size() && i < 5; i++)
      check("t2_rotation", 64'(grant_log[i]), 64'(i % NS));
    bubble_exact = 0;
    lat_en       = 0;

    // 3) 5-beat packet from source 2 under 1,0,0,1 backpressure
    ready_mode = 2;
    pat_cnt    = 0;
    add_pkt(2, 5, 1);
    schedule(4'b1111);
    drive();
    run_until_drained("t3", 80);

    // 4a) only sources 0 and 2 enabled although all are valid
    ready_mode = 0;
    src_en     = 4'b0101;
    for (int k = 0; k < NS; k++) add_pkt(k, 1, 0);
    add_pkt(0, 1, 0);
    add_pkt(2, 1, 0);
    schedule(4'b0101);
    drive();
    run_until_drained("t4a", 60);
    for (int i = 1; i < grant_log.size(); i++)
      check("t4a_alternate", 64'(grant_log[i]), 64'(grant_log[i-1] == 0 ? 2 : 0));
    src_q[1].delete();
    src_q[3].delete();
    drive();
    tick();

    // 4b) clearing source 0's enable mid-packet does not truncate it
    add_pkt(0, 4, 0);
    add_pkt(2, 1, 0);
    schedule(4'b0101);
    drive();
    n = 0;
    while (!mid_pkt[0] && n < 40) begin
      tick();
      n++;
    end
    check("t4b_started", 64'(mid_pkt[0]), 64'(1));
    src_en = 4'b0100;
    run_until_drained("t4b", 60);
    src_en = 4'b1111;

    // randomized rounds: random enables, packet lengths, keeps, valid gaps and backpressure
    for (int r = 0; r < 20; r++) begin
      logic [NS-1:0] en;
      en         = 4'($urandom_range(1, 15));
      src_en     = en;
      ready_mode = 1;
      gap_en     = 1;
      for (int k = 0; k < NS; k++)
        if (en[k]) begin
          n = $urandom_range(0, 3);
          for (int p = 0; p < n; p++) add_pkt(k, $urandom_range(1, MB), 1);
        end
      schedule(en);
      drive();
      run_until_drained("rand", 3000);
    end
    ready_mode = 0;
    gap_en     = 0;
    src_en     = 4'b1111;

    // 5) overlong 6-beat packet from source 1 with MAX_BEATS=4
    add_pkt(1, 6, 0);
    schedule(4'b1111);
    drive();
    run_until_drained("t5", 60);
    check("t5_err_sticky", 64'(err_overlong), 64'(1));
    tick();
    check("t5_err_still", 64'(err_overlong), 64'(1));

    // 6) reset during beat 2 of 4, then a clean packet from source 0
    add_pkt(0, 4, 0);
    schedule(4'b1111);
    drive();
    n = 0;
    while (beat_no[0] < 2 && n < 40) begin
      tick();
      n++;
    end
    check("t6_reached_beat2", 64'(beat_no[0]), 64'(2));
    apply_reset();
    add_pkt(0, 2, 0);
    schedule(4'b1111);
    drive();
    run_until_drained("t6", 50);
    check("t6_pkt_count", 64'(pkt_count), 64'(1));
    check("t6_grant_idx", 64'(grant_idx), 64'(0));
    check("t6_err_clear", 64'(err_overlong), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
